rt_ibex_hws_sequencer: RTL and testbench

// Sequences the RT-IBEX hardware stacking unit for interrupt entry/exit. Accepts qualified IRQs and ID-stage

---
 rtl/rt_ibex_hws_sequencer_pkg.sv | 32 +++
 rtl/rt_ibex_hws_lvl_stack.sv | 52 +++++
 rtl/rt_ibex_hws_sequencer.sv | 149 ++++++++++++++
 tb/tb_rt_ibex_hws_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rt_ibex_hws_sequencer_pkg.sv
// Shared types and constants for the RT-IBEX hardware-stacking sequencer.
package rt_ibex_hws_sequencer_pkg;

    typedef enum logic {
        HWS_SAVE    = 1'b0,
        HWS_RESTORE = 1'b1
    } hw_stacking_mode_t;

    typedef enum logic [2:0] {
        HWS_SEQ_IDLE      = 3'd0,
        HWS_SEQ_RUN       = 3'd1,
        HWS_SEQ_WAIT_IDLE = 3'd2,
        HWS_SEQ_SAVE_GO   = 3'd3,
        HWS_SEQ_SAVE_BUSY = 3'd4,
        HWS_SEQ_MRET_CHK  = 3'd5,
        HWS_SEQ_RST_GO    = 3'd6,
        HWS_SEQ_RST_BUSY  = 3'd7
    } hws_seq_state_e;

    localparam int HWS_NEST_DEPTH = 4;

    // Plain-vector mirrors of the state encoding for the FSM register.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RUN       = 3'd1;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd2;
    localparam logic [2:0] ST_SAVE_GO   = 3'd3;
    localparam logic [2:0] ST_SAVE_BUSY = 3'd4;
    localparam logic [2:0] ST_MRET_CHK  = 3'd5;
    localparam logic [2:0] ST_RST_GO    = 3'd6;
    localparam logic [2:0] ST_RST_BUSY  = 3'd7;

endpackage

// File: rtl/rt_ibex_hws_lvl_stack.sv
// LIFO of preempted execution levels; one entry per nested handler.
module rt_ibex_hws_lvl_stack
    import rt_ibex_hws_sequencer_pkg::*;
#(
    parameter int NEST_DEPTH = HWS_NEST_DEPTH,
    parameter int LVL_W      = 4,
    parameter int DW         = $clog2(NEST_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [LVL_W-1:0] push_lvl_i,
    input  logic             pop_i,
    output logic [LVL_W-1:0] top_o,
    output logic [DW-1:0]    depth_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [LVL_W-1:0] mem_q [NEST_DEPTH];
    logic [DW-1:0]    depth_q;

    assign full_o  = (depth_q == DW'(NEST_DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    always_comb begin
        top_o = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) top_o = mem_q[i];
        end
    end

    // Illegal push/pop requests are dropped so the stack never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth_q <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i && !full_o) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (depth_q == DW'(i)) mem_q[i] <= push_lvl_i;
            end
            depth_q <= depth_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/rt_ibex_hws_sequencer.sv
// Interrupt entry/exit sequencer: drives the stacking-unit handshake, tracks
// nesting levels and tail-chains a pending irq on MRET.
module rt_ibex_hws_sequencer
    import rt_ibex_hws_sequencer_pkg::*;
#(
    parameter int NEST_DEPTH = HWS_NEST_DEPTH,
    parameter int LVL_W      = 4,
    parameter int ID_W       = 5,
    localparam int DW        = $clog2(NEST_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             irq_valid_i,
    input  logic [ID_W-1:0]  irq_id_i,
    input  logic [LVL_W-1:0] irq_lvl_i,
    input  logic             mret_i,
    input  logic             pipe_idle_i,
    output logic             hws_start_o,
    output logic             hws_mode_o,
    input  logic             hws_done_i,
    output logic             hws_ack_o,
    output logic             fetch_halt_o,
    output logic             irq_ack_o,
    output logic [ID_W-1:0]  irq_ack_id_o,
    output logic             pc_set_vec_o,
    output logic             pc_set_ret_o,
    output logic [LVL_W-1:0] cur_lvl_o,
    output logic [DW-1:0]    depth_o
);

    logic [2:0]       state_q, state_d;
    logic [LVL_W-1:0] cur_lvl_q, cur_lvl_d;
    logic [LVL_W-1:0] lvl_q;
    logic [ID_W-1:0]  id_q;
    logic             push, pop;
    logic [LVL_W-1:0] top_lvl;
    logic             stk_full, stk_empty;
    logic             take, tail;

    rt_ibex_hws_lvl_stack #(
        .NEST_DEPTH(NEST_DEPTH),
        .LVL_W     (LVL_W)
    ) u_lvl_stack (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push),
        .push_lvl_i(cur_lvl_q),
        .pop_i     (pop),
        .top_o     (top_lvl),
        .depth_o   (depth_o),
        .full_o    (stk_full),
        .empty_o   (stk_empty)
    );

    assign take = irq_valid_i && (irq_lvl_i > cur_lvl_q) && !stk_full;
    // Tail-chain compares against the level MRET would return to, not the current one.
    assign tail = irq_valid_i && (irq_lvl_i > top_lvl);

    assign cur_lvl_o  = cur_lvl_q;
    assign hws_mode_o = (state_q == ST_RST_GO || state_q == ST_RST_BUSY) ? HWS_RESTORE : HWS_SAVE;

    always_comb begin
        state_d      = state_q;
        cur_lvl_d    = cur_lvl_q;
        hws_start_o  = 1'b0;
        hws_ack_o    = 1'b0;
        fetch_halt_o = 1'b0;
        irq_ack_o    = 1'b0;
        irq_ack_id_o = '0;
        pc_set_vec_o = 1'b0;
        pc_set_ret_o = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (mret_i && !stk_empty) state_d = ST_MRET_CHK;
                else if (take)            state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                fetch_halt_o = 1'b1;
                if (!take)            state_d = ST_RUN;
                else if (pipe_idle_i) state_d = ST_SAVE_GO;
            end
            ST_SAVE_GO: begin
                // A stale done from the unit would alias the new request; hold off.
                fetch_halt_o = 1'b1;
                hws_start_o  = !hws_done_i;
                if (!hws_done_i) state_d = ST_SAVE_BUSY;
            end
            ST_SAVE_BUSY: begin
                fetch_halt_o = 1'b1;
                if (hws_done_i) begin
                    hws_ack_o    = 1'b1;
                    push         = 1'b1;
                    cur_lvl_d    = lvl_q;
                    irq_ack_o    = 1'b1;
                    irq_ack_id_o = id_q;
                    pc_set_vec_o = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            ST_MRET_CHK: begin
                fetch_halt_o = 1'b1;
                if (tail) begin
                    irq_ack_o    = 1'b1;
                    irq_ack_id_o = irq_id_i;
                    pc_set_vec_o = 1'b1;
                    cur_lvl_d    = irq_lvl_i;
                    state_d      = ST_RUN;
                end else begin
                    state_d = ST_RST_GO;
                end
            end
            ST_RST_GO: begin
                fetch_halt_o = 1'b1;
                hws_start_o  = !hws_done_i;
                if (!hws_done_i) state_d = ST_RST_BUSY;
            end
            ST_RST_BUSY: begin
                fetch_halt_o = 1'b1;
                if (hws_done_i) begin
                    hws_ack_o    = 1'b1;
                    pop          = 1'b1;
                    cur_lvl_d    = top_lvl;
                    pc_set_ret_o = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cur_lvl_q <= '0;
            lvl_q     <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            cur_lvl_q <= cur_lvl_d;
            if (state_q == ST_WAIT_IDLE) begin
                lvl_q <= irq_lvl_i;
                id_q  <= irq_id_i;
            end
        end
    end

endmodule

// File: tb/tb_rt_ibex_hws_sequencer.sv
// Directed bench for the hardware-stacking sequencer with NEST_DEPTH=2.
module tb_rt_ibex_hws_sequencer;

    localparam int ND = 2;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       irq_valid_i = 1'b0;
    logic [4:0] irq_id_i = '0;
    logic [3:0] irq_lvl_i = '0;
    logic       mret_i = 1'b0;
    logic       pipe_idle_i = 1'b0;
    logic       hws_done_i = 1'b0;
    logic       hws_start_o, hws_mode_o, hws_ack_o, fetch_halt_o;
    logic       irq_ack_o, pc_set_vec_o, pc_set_ret_o;
    logic [4:0] irq_ack_id_o;
    logic [3:0] cur_lvl_o;
    logic [1:0] depth_o;

    int n_chk = 0;
    int n_pass = 0;

    rt_ibex_hws_sequencer #(.NEST_DEPTH(ND), .LVL_W(4), .ID_W(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .irq_valid_i(irq_valid_i), .irq_id_i(irq_id_i), .irq_lvl_i(irq_lvl_i),
        .mret_i(mret_i), .pipe_idle_i(pipe_idle_i),
        .hws_start_o(hws_start_o), .hws_mode_o(hws_mode_o), .hws_done_i(hws_done_i),
        .hws_ack_o(hws_ack_o), .fetch_halt_o(fetch_halt_o),
        .irq_ack_o(irq_ack_o), .irq_ack_id_o(irq_ack_id_o),
        .pc_set_vec_o(pc_set_vec_o), .pc_set_ret_o(pc_set_ret_o),
        .cur_lvl_o(cur_lvl_o), .depth_o(depth_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // {start, mode, ack, halt, irq_ack, vec, ret}
    function automatic logic [6:0] outs();
        return {hws_start_o, hws_mode_o, hws_ack_o, fetch_halt_o, irq_ack_o, pc_set_vec_o, pc_set_ret_o};
    endfunction

    // Waits for start, plays a 10-cycle stacking unit and leaves done high in the ack cycle.
    task automatic hws_run(input string tag, input logic exp_mode, input int exp_lat);
        int cnt = 0;
        while (!hws_start_o && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({tag, "_lat"}, cnt, exp_lat);
        chk({tag, "_mode"}, hws_mode_o, exp_mode);
        tick();
        chk({tag, "_busy"}, {hws_start_o, fetch_halt_o, hws_ack_o, hws_mode_o}, {3'b010, exp_mode});
        repeat (9) tick();
        hws_done_i = 1'b1;
        #1;
    endtask

    task automatic end_ack();
        tick();
        hws_done_i = 1'b0;
    endtask

    task automatic pulse_mret();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
    endtask

    initial begin
        logic seen;
        repeat (3) tick();
        chk("rst_outs", outs(), 7'b0);
        chk("rst_lvl_depth", {cur_lvl_o, depth_o, irq_ack_id_o}, 0);
        rst_ni = 1'b1;
        pipe_idle_i = 1'b1;

        // Single irq entry then exit
        irq_valid_i = 1'b1; irq_id_i = 5'd3; irq_lvl_i = 4'd2;
        hws_run("save1", 1'b0, 2);
        chk("save1_ack", {hws_ack_o, irq_ack_o, pc_set_vec_o, pc_set_ret_o}, 4'b1110);
        chk("save1_id", irq_ack_id_o, 3);
        end_ack();
        irq_valid_i = 1'b0;
        chk("save1_after", {cur_lvl_o, depth_o, fetch_halt_o, hws_ack_o}, {4'd2, 2'd1, 2'b00});

        pulse_mret();
        chk("mchk1", {irq_ack_o, pc_set_vec_o, hws_start_o, fetch_halt_o}, 4'b0001);
        hws_run("rst1", 1'b1, 1);
        chk("rst1_ack", {hws_ack_o, irq_ack_o, pc_set_vec_o, pc_set_ret_o}, 4'b1001);
        end_ack();
        chk("rst1_after", {cur_lvl_o, depth_o, pc_set_ret_o}, 0);

        // MRET at depth 0 is ignored
        pulse_mret();
        chk("mret_d0", {fetch_halt_o, hws_start_o}, 0);

        // irq withdrawn while waiting for the pipe to drain
        pipe_idle_i = 1'b0;
        irq_valid_i = 1'b1; irq_id_i = 5'd5; irq_lvl_i = 4'd1;
        tick();
        chk("wait_halt", fetch_halt_o, 1);
        tick();
        irq_valid_i = 1'b0;
        tick();
        chk("wait_abort", {fetch_halt_o, hws_start_o}, 0);
        pipe_idle_i = 1'b1;

        // Nesting: lvl2 then lvl5
        irq_valid_i = 1'b1; irq_id_i = 5'd3; irq_lvl_i = 4'd2;
        hws_run("save2", 1'b0, 2);
        chk("save2_id", {irq_ack_o, irq_ack_id_o}, {1'b1, 5'd3});
        end_ack();
        irq_id_i = 5'd7; irq_lvl_i = 4'd5;
        hws_run("save3", 1'b0, 2);
        chk("save3_id", {irq_ack_o, pc_set_vec_o, irq_ack_id_o}, {2'b11, 5'd7});
        end_ack();
        chk("nest_after", {cur_lvl_o, depth_o}, {4'd5, 2'd2});

        irq_id_i = 5'd1; irq_lvl_i = 4'd1;
        seen = 1'b0;
        repeat (4) begin tick(); seen |= hws_start_o | fetch_halt_o; end
        chk("low_lvl_ignored", seen, 0);

        // Depth full: lvl15 waits, then tail-chains on MRET
        irq_id_i = 5'd9; irq_lvl_i = 4'd15;
        seen = 1'b0;
        repeat (4) begin tick(); seen |= hws_start_o | fetch_halt_o; end
        chk("full_ignored", seen, 0);
        pulse_mret();
        chk("tail_full", {irq_ack_o, pc_set_vec_o, hws_start_o, hws_ack_o}, 4'b1100);
        chk("tail_full_id", irq_ack_id_o, 9);
        tick();
        irq_valid_i = 1'b0;
        chk("tail_full_after", {cur_lvl_o, depth_o, irq_ack_o}, {4'd15, 2'd2, 1'b0});

        pulse_mret();
        hws_run("rst2", 1'b1, 1);
        chk("rst2_ret", pc_set_ret_o, 1);
        end_ack();
        chk("rst2_after", {cur_lvl_o, depth_o}, {4'd2, 2'd1});

        // Tail-chain from lvl2 into pending lvl1
        irq_valid_i = 1'b1; irq_id_i = 5'd4; irq_lvl_i = 4'd1;
        tick();
        chk("lvl1_pending", fetch_halt_o, 0);
        pulse_mret();
        chk("tail", {irq_ack_o, pc_set_vec_o, hws_start_o}, 3'b110);
        chk("tail_id", irq_ack_id_o, 4);
        tick();
        irq_valid_i = 1'b0;
        chk("tail_after", {cur_lvl_o, depth_o, hws_start_o}, {4'd1, 2'd1, 1'b0});
        pulse_mret();
        hws_run("rst3", 1'b1, 1);
        end_ack();
        chk("rst3_after", {cur_lvl_o, depth_o}, 0);

        // Reset in the middle of a SAVE
        irq_valid_i = 1'b1; irq_id_i = 5'd6; irq_lvl_i = 4'd3;
        repeat (3) tick();
        chk("mid_busy", {hws_start_o, fetch_halt_o, hws_mode_o}, 3'b010);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_outs", outs(), 7'b0);
        chk("mid_rst_depth", {cur_lvl_o, depth_o}, 0);
        tick();
        rst_ni = 1'b1;
        hws_run("save4", 1'b0, 2);
        chk("save4_id", {irq_ack_o, irq_ack_id_o}, {1'b1, 5'd6});
        end_ack();
        chk("save4_after", {cur_lvl_o, depth_o}, {4'd3, 2'd1});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
